// File: rtl/afu_transpose_pkg.sv
// Shared types and width helpers for the AFU streaming tile-transpose engine.
// Imported by the tile bank and the top-level control.
package afu_transpose_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  function automatic int line_w(input int lanes, input int dw);
    return lanes * dw;
  endfunction

  function automatic int idx_w(input int lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/afu_transpose_stream_bank.sv
// One LANESxLANES tile buffer: row-wise write port, column-wise read port.
// Rows at or above rows_valid read back as zero so partial tiles come out padded.
module transpose_tile_bank
  import afu_transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 32,
  localparam int IDX_W     = idx_w(LANES),
  localparam int LINE_W    = line_w(LANES, DATA_WIDTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_col,
  input  logic [IDX_W:0]    rows_valid,
  output logic [LINE_W-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [LANES][LANES];
  logic [DATA_WIDTH-1:0] mem_d [LANES][LANES];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        mem_d[wr_row][j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Contents need no reset: stale rows are masked by rows_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < LANES; r++) begin
      if ((IDX_W+1)'(r) < rows_valid) begin
        rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][rd_col];
      end
    end
  end

endmodule

// File: rtl/afu_transpose_stream.sv
// Streaming LANESxLANES tile transpose with ping-pong banks, output
// backpressure, trailing-tile padding, bypass mode and completion pulse.
module afu_transpose_stream
  import afu_transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        ctx_length,
  input  logic                        bypass,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_WIDTH-1:0]        out_line_count
);

  localparam int LINE_W = line_w(LANES, DATA_WIDTH);
  localparam int IDX_W  = idx_w(LANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);
  localparam logic [CNT_WIDTH-1:0] TMASK = CNT_WIDTH'(LANES - 1);

  logic busy_q, busy_d;
  logic byp_q, byp_d;
  logic done_q, done_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] tot_q, tot_d;
  logic [CNT_WIDTH-1:0] lin_q, lin_d;
  logic [CNT_WIDTH-1:0] lout_q, lout_d;
  logic ov_q, ov_d;
  logic [LINE_W-1:0] od_q, od_d;
  bank_state_e st_q [2];
  bank_state_e st_d [2];
  logic [IDX_W:0] rv_q [2];
  logic [IDX_W:0] rv_d [2];
  logic ws_q, ws_d;
  logic rs_q, rs_d;
  logic [IDX_W-1:0] wr_row_q, wr_row_d;
  logic [IDX_W-1:0] rd_col_q, rd_col_d;

  logic [1:0] wr_en;
  logic [LINE_W-1:0] bank_rd [2];
  logic start_ok, wr_ok, rd_ok, out_free;
  logic in_fire, out_fire, load, tile_end;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_tile_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .LANES     (LANES)
    ) u_bank (
      .clk       (clk),
      .wr_en     (wr_en[b]),
      .wr_row    (wr_row_q),
      .wr_data   (in_data),
      .rd_col    (rd_col_q),
      .rows_valid(rv_q[b]),
      .rd_data   (bank_rd[b])
    );
  end

  always_comb begin
    start_ok = start & ~busy_q;
    wr_ok    = (st_q[ws_q] == BANK_EMPTY)
             | (st_q[ws_q] == BANK_FILLING);
    rd_ok    = (st_q[rs_q] == BANK_FULL)
             | (st_q[rs_q] == BANK_DRAINING);
    out_free = ~ov_q | out_ready;
    in_ready = busy_q & (lin_q < len_q)
             & (byp_q ? out_free : wr_ok);
    in_fire  = in_valid & in_ready;
    out_fire = ov_q & out_ready;
    load     = ~byp_q & out_free & rd_ok;
    tile_end = (wr_row_q == LAST)
             | (lin_q + CNT_WIDTH'(1) == len_q);

    busy_d   = busy_q;
    byp_d    = byp_q;
    len_d    = len_q;
    tot_d    = tot_q;
    lin_d    = lin_q + CNT_WIDTH'(in_fire);
    lout_d   = lout_q + CNT_WIDTH'(out_fire);
    done_d   = 1'b0;
    ov_d     = ov_q & ~out_ready;
    od_d     = od_q;
    st_d     = st_q;
    rv_d     = rv_q;
    ws_d     = ws_q;
    rs_d     = rs_q;
    wr_row_d = wr_row_q;
    rd_col_d = rd_col_q;
    wr_en    = '0;

    if (start_ok) begin
      len_d  = ctx_length;
      byp_d  = bypass;
      tot_d  = bypass ? ctx_length
             : (ctx_length + TMASK) & ~TMASK;
      lin_d  = '0;
      lout_d = '0;
      busy_d = (ctx_length != '0);
      done_d = (ctx_length == '0);
    end

    if (in_fire & byp_q) begin
      od_d = in_data;
      ov_d = 1'b1;
    end

    if (in_fire & ~byp_q) begin
      wr_en[ws_q] = 1'b1;
      if (tile_end) begin
        st_d[ws_q] = BANK_FULL;
        rv_d[ws_q] = (IDX_W+1)'(wr_row_q)
                   + (IDX_W+1)'(1);
        ws_d       = ~ws_q;
        wr_row_d   = '0;
      end else begin
        st_d[ws_q] = BANK_FILLING;
        wr_row_d   = wr_row_q + IDX_W'(1);
      end
    end

    // The write and read banks never coincide: states are disjoint.
    if (load) begin
      od_d = bank_rd[rs_q];
      ov_d = 1'b1;
      if (rd_col_q == LAST) begin
        st_d[rs_q] = BANK_EMPTY;
        rs_d       = ~rs_q;
        rd_col_d   = '0;
      end else begin
        st_d[rs_q] = BANK_DRAINING;
        rd_col_d   = rd_col_q + IDX_W'(1);
      end
    end

    if (busy_q & out_fire
        & (lout_q + CNT_WIDTH'(1) == tot_q)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      byp_q    <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= '0;
      tot_q    <= '0;
      lin_q    <= '0;
      lout_q   <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      st_q[0]  <= BANK_EMPTY;
      st_q[1]  <= BANK_EMPTY;
      rv_q[0]  <= '0;
      rv_q[1]  <= '0;
      ws_q     <= 1'b0;
      rs_q     <= 1'b0;
      wr_row_q <= '0;
      rd_col_q <= '0;
    end else begin
      busy_q   <= busy_d;
      byp_q    <= byp_d;
      done_q   <= done_d;
      len_q    <= len_d;
      tot_q    <= tot_d;
      lin_q    <= lin_d;
      lout_q   <= lout_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      st_q     <= st_d;
      rv_q     <= rv_d;
      ws_q     <= ws_d;
      rs_q     <= rs_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
    end
  end

  assign out_data       = od_q;
  assign out_valid      = ov_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign out_line_count = lout_q;

endmodule

// File: tb/tb_afu_transpose_stream.sv
// Scoreboard bench for afu_transpose_stream: a reference tile model
// pushes expected lines as inputs are accepted; a monitor pops them.
module tb_afu_transpose_stream;

  localparam int DW = 16;
  localparam int LN = 32;
  localparam int CW = 32;
  localparam int LW = DW * LN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic bypass = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [CW-1:0] ctx_length = '0;
  logic [LW-1:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [LW-1:0] out_data;
  logic [CW-1:0] out_line_count;

  int checks = 0;
  int errors = 0;
  int in_acc = 0;
  int out_seen = 0;
  int done_cnt = 0;
  int done_base = 0;
  logic [LW-1:0] exp_q [$];
  logic [LW-1:0] tile [LN];
  logic [LW-1:0] mon_exp;

  always #5 clk = ~clk;

  afu_transpose_stream #(
    .DATA_WIDTH(DW),
    .LANES     (LN),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ctx_length    (ctx_length),
    .bypass        (bypass),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done),
    .out_line_count(out_line_count)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected line %0d got %h",
                 out_seen, out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL out_line %0d got %h want %h",
                   out_seen, out_data, mon_exp);
        end
      end
      out_seen++;
    end
  end

  function automatic logic [LW-1:0] mkline(input int k);
    logic [LW-1:0] l;
    for (int j = 0; j < LN; j++) begin
      l[j*DW +: DW] = {k[7:0], j[7:0]};
    end
    return l;
  endfunction

  task automatic do_start(input int len, input bit byp);
    @(posedge clk); #1;
    in_acc = 0;
    out_seen = 0;
    done_base = done_cnt;
    ctx_length = len;
    bypass = byp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_ctx(input int len, input int n,
                           input bit byp, input int base);
    int k = 0;
    int cyc = 0;
    int row = 0;
    logic [LW-1:0] e;
    while (k < n && cyc < 2000) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = mkline(base + k);
      @(negedge clk);
      if (in_ready) begin
        if (byp) begin
          exp_q.push_back(in_data);
        end else begin
          tile[row] = in_data;
          if (row == LN - 1 || k == len - 1) begin
            for (int c = 0; c < LN; c++) begin
              e = '0;
              for (int r = 0; r < LN; r++)
                if (r <= row) e[r*DW +: DW] = tile[r][c*DW +: DW];
              exp_q.push_back(e);
            end
            row = 0;
          end else begin
            row++;
          end
        end
        k++;
        in_acc++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (k < n) begin
      errors++;
      $display("FAIL drive_timeout accepted %0d want %0d", k, n);
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (done_cnt == done_base && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cyc >= 1000) begin
      errors++;
      $display("FAIL done_timeout waited %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %b want 0", done);
    end
    if (out_data !== '0) begin
      errors++; $display("FAIL rst_out_data got %h want 0", out_data);
    end
    if (out_line_count !== '0) begin
      errors++;
      $display("FAIL rst_count got %0d want 0", out_line_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc = 0;
    logic ov_before, ov_after;
    out_ready = 1'b1;
    do_start(32, 0);
    fork
      drive_ctx(32, 32, 0, 0);
      begin
        while (in_acc < 32 && cyc < 500) begin
          @(negedge clk); #1;
          cyc++;
        end
        @(posedge clk); #1;
        ov_before = out_valid;
        @(posedge clk); #1;
        ov_after = out_valid;
      end
    join
    wait_done();
    checks += 5;
    if (ov_before !== 1'b0) begin
      errors++; $display("FAIL basic_lat_early got %b want 0", ov_before);
    end
    if (ov_after !== 1'b1) begin
      errors++; $display("FAIL basic_lat got %b want 1", ov_after);
    end
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL basic_done got %0d want 1", done_cnt - done_base);
    end
    if (out_line_count !== 32) begin
      errors++;
      $display("FAIL basic_count got %0d want 32", out_line_count);
    end
    if (out_seen != 32 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_lines got %0d left %0d want 32 left 0",
               out_seen, exp_q.size());
    end
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    do_start(40, 0);
    drive_ctx(40, 40, 0, 0);
    wait_done();
    checks += 3;
    if (out_seen != 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL part_lines got %0d left %0d want 64 left 0",
               out_seen, exp_q.size());
    end
    if (out_line_count !== 64) begin
      errors++;
      $display("FAIL part_count got %0d want 64", out_line_count);
    end
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL part_done got %0d want 1", done_cnt - done_base);
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    int cyc = 0;
    int first_drop = -1;
    int unstable = 0;
    logic ov_stall;
    logic [LW-1:0] snap;
    out_ready = 1'b1;
    do_start(96, 0);
    fork
      drive_ctx(96, 96, 0, 0);
      begin
        while (in_acc < 96 && cyc < 600) begin
          @(negedge clk); #1;
          if (in_acc >= 1 && in_valid && !in_ready) drops++;
          cyc++;
        end
      end
    join
    wait_done();
    checks += 3;
    if (drops != 0) begin
      errors++; $display("FAIL b2b_ready_drop got %0d want 0", drops);
    end
    if (out_line_count !== 96) begin
      errors++;
      $display("FAIL b2b_count got %0d want 96", out_line_count);
    end
    if (out_seen != 96 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_lines got %0d left %0d want 96 left 0",
               out_seen, exp_q.size());
    end

    do_start(96, 0);
    cyc = 0;
    fork
      drive_ctx(96, 96, 0, 0);
      begin
        int c2 = 0;
        while (in_acc < 96 && c2 < 600) begin
          @(negedge clk); #1;
          if (in_valid && !in_ready && first_drop < 0)
            first_drop = in_acc;
          c2++;
        end
      end
      begin
        while (out_seen < 5 && cyc < 600) begin
          @(negedge clk); #1;
          cyc++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        ov_stall = out_valid;
        snap = out_data;
        repeat (10) begin
          @(negedge clk);
          if (out_data !== snap || !out_valid) unstable++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done();
    checks += 5;
    if (ov_stall !== 1'b1) begin
      errors++; $display("FAIL bp_valid got %b want 1", ov_stall);
    end
    if (unstable != 0) begin
      errors++; $display("FAIL bp_stable got %0d want 0", unstable);
    end
    if (first_drop != 64) begin
      errors++;
      $display("FAIL bp_ready_drop_at got %0d want 64", first_drop);
    end
    if (out_seen != 96 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_lines got %0d left %0d want 96 left 0",
               out_seen, exp_q.size());
    end
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL bp_done got %0d want 1", done_cnt - done_base);
    end
  endtask

  task automatic test_bypass();
    int late = 0;
    out_ready = 1'b1;
    do_start(5, 1);
    fork
      drive_ctx(5, 5, 1, 1);
      begin
        logic fire_now;
        repeat (10) begin
          @(negedge clk); #1;
          fire_now = in_valid & in_ready;
          @(posedge clk); #1;
          if (out_valid !== fire_now) late++;
        end
      end
    join
    wait_done();
    checks += 4;
    if (late != 0) begin
      errors++; $display("FAIL byp_latency got %0d want 0", late);
    end
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL byp_done got %0d want 1", done_cnt - done_base);
    end
    if (out_line_count !== 5) begin
      errors++;
      $display("FAIL byp_count got %0d want 5", out_line_count);
    end
    if (out_seen != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL byp_lines got %0d left %0d want 5 left 0",
               out_seen, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    int ovs = 0;
    do_start(0, 0);
    checks += 4;
    if (done !== 1'b1) begin
      errors++; $display("FAIL zero_done got %b want 1", done);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL zero_busy got %b want 0", busy);
    end
    @(posedge clk); #1;
    if (done !== 1'b0) begin
      errors++; $display("FAIL zero_done_pulse got %b want 0", done);
    end
    repeat (5) begin
      if (out_valid !== 1'b0) ovs++;
      @(posedge clk); #1;
    end
    if (ovs != 0) begin
      errors++; $display("FAIL zero_out_valid got %0d want 0", ovs);
    end
  endtask

  task automatic test_start_while_busy();
    do_start(32, 0);
    checks += 4;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL sb_busy got %b want 1", busy);
    end
    @(posedge clk); #1;
    ctx_length = 0;
    bypass = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (busy !== 1'b1 || done_cnt != done_base) begin
      errors++;
      $display("FAIL sb_ignored got busy %b done %0d want 1 0",
               busy, done_cnt - done_base);
    end
    drive_ctx(32, 32, 0, 7);
    wait_done();
    if (out_line_count !== 32) begin
      errors++;
      $display("FAIL sb_count got %0d want 32", out_line_count);
    end
    if (out_seen != 32 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_lines got %0d left %0d want 32 left 0",
               out_seen, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    do_start(32, 0);
    drive_ctx(32, 17, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks += 4;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mrst_in_ready got %b want 0", in_ready);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mrst_out_valid got %b want 0", out_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mrst_busy got %b want 0", busy);
    end
    repeat (40) @(posedge clk);
    #1;
    if (out_seen != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mrst_no_output got %0d left %0d want 0 0",
               out_seen, exp_q.size());
    end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_bypass();
    test_zero_len();
    test_start_while_busy();
    test_reset_midstream();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
